pb_event: RTL
=============

# pb_event

Push-button event controller sitting directly downstream of the push-button debouncer; it consumes the 5-bit debounced level vector and turns it into CPU-visible events. Per button it latches press (rising-edge) and long-hold flags, and counts presses. It also raises a maskable interrupt. All registers sit on the CPU's 8-bit memory-mapped peripheral bus at 0xf9–0xfd, adjacent to the debouncer's level register at 0xf8.

## Interface
Parameters:
- HOLD_W, 24: width of per-button hold counters.
- HOLD_CYCLES, 24'd12_000_000: consecutive high cycles for a long-hold event; legal range 2..2^HOLD_W-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- addr  in  8  CPU address for reads and writes.
- wdata  in  8  CPU write data.
- we  in  1  write strobe; a write occurs on a clk edge with we=1.
- state  in  5  debounced button levels from the debouncer; 1 = pressed.
- out  out  8  read data; combinational from addr; 0 for unmapped addresses.
- irq  out  1  registered interrupt request, level-sensitive.

## Operation
Register map (bits 7:5 read 0 unless noted):
- 0xf9 PRESS[4:0]: sticky flags. Bit i sets on a 0→1 transition of state[i]. Writing 1 to a bit clears it (W1C).
- 0xfa HOLD[4:0]: sticky flags. Bit i sets once per press, when state[i] has been 1 for HOLD_CYCLES consecutive cycles. W1C.
- 0xfb PMASK[4:0]: read/write press-interrupt enables.
- 0xfc HMASK[4:0]: read/write hold-interrupt enables.
- 0xfd COUNT[7:0]: total press count, modulo 256. Any write clears it to 0.

Edge detect:
- prev[4:0] <= state every cycle.
- rise = state & ~prev.

Hold counter (per button):
- state[i]=0: hcnt_i <= 0.
- state[i]=1 and hcnt_i < HOLD_CYCLES: hcnt_i <= hcnt_i + 1.
- hcnt_i saturates at HOLD_CYCLES.
- HOLD[i] sets in the cycle hcnt_i goes HOLD_CYCLES-1 → HOLD_CYCLES. No re-trigger until state[i] returns to 0.

COUNT:
- COUNT <= COUNT + popcount(rise), 8-bit wrap.
- Simultaneous rises on several buttons add together.

Interrupt:
- irq <= |(PRESS & PMASK) | |(HOLD & HMASK).

Boundary rules:
- Set and W1C on the same bit in the same cycle: set wins, flag stays 1.
- COUNT write and rise in the same cycle: COUNT <= popcount(rise).
- Writes to unmapped addresses and to 0xf8 are ignored.
- Writing mask bits while a flag is pending changes irq on the next cycle.
- A state pulse shorter than HOLD_CYCLES clears hcnt and sets no HOLD flag.

## Timing
- Reset values: prev, PRESS, HOLD, PMASK, HMASK, COUNT, every hcnt, and irq are all 0. out = 0 unless addr is mapped; mapped registers read 0.
- Reset mid-hold discards the count. A button still held after reset produces a fresh PRESS one cycle after rst_n deasserts, if state=1.
- Press latency: state[i] rises in cycle N; PRESS[i] and COUNT are updated at the edge ending cycle N and visible in cycle N+1; irq is high in cycle N+2.
- Hold latency: state[i] is first high in cycle N; HOLD[i] is visible in cycle N+HOLD_CYCLES; irq one cycle later.
- W1C/write: takes effect at the edge of the write cycle; the read in the next cycle shows the new value; irq drops one cycle after that.
- out is purely combinational, with no read side effects.

## Structure
- Package pb_pkg:
  - address constants PB_LEVEL_ADDR=8'hf8, PB_PRESS_ADDR=8'hf9, PB_HOLD_ADDR=8'hfa, PB_PMASK_ADDR=8'hfb, PB_HMASK_ADDR=8'hfc, PB_COUNT_ADDR=8'hfd.
  - NUM_PB=5.
  - the debouncer adopts PB_LEVEL_ADDR from this package.
- Sub-module pb_event_chan, instantiated NUM_PB times. Each instance owns prev, hcnt, the PRESS and HOLD bits, and their W1C logic, and outputs rise.
- The top level owns the masks, COUNT, popcount, irq, and the read mux.

## Test plan
All scenarios use HOLD_CYCLES=4.
- Reset: hold rst_n=0 for 2 cycles with state=5'h1f, then release → out=0 at every address during reset; PRESS=5'h1f one cycle after release; COUNT=5.
- Single press: state[2] 0→1 for 2 cycles → PRESS=5'h04, HOLD=0, COUNT=1; irq stays 0 with PMASK=0. Set PMASK=5'h04 → irq=1 one cycle later.
- Long hold: state[0]=1 for 10 cycles → HOLD[0] sets exactly 4 cycles after the first high cycle and is set only once. Clear via W1C 0x01 at 0xfa while still held → HOLD stays 0.
- Set/clear collision: write 5'h02 to 0xf9 in the same cycle state[1] rises → PRESS[1]=1.
- COUNT: 255 single presses followed by a double press on buttons 3 and 4 → COUNT=1 (wrap). A write to 0xfd concurrent with one rise → COUNT=1.
- Masked irq: PRESS=5'h08, HOLD=5'h08, PMASK=0, HMASK=5'h08 → irq=1. W1C HOLD → irq=0 two cycles after the write.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared constants for the push-button event block and its neighbouring debouncer.
// Also holds the press-counting helper used by the top level.
package pb_pkg;

    localparam int NUM_PB = 5;

    localparam logic [7:0] PB_LEVEL_ADDR = 8'hf8;
    localparam logic [7:0] PB_PRESS_ADDR = 8'hf9;
    localparam logic [7:0] PB_HOLD_ADDR  = 8'hfa;
    localparam logic [7:0] PB_PMASK_ADDR = 8'hfb;
    localparam logic [7:0] PB_HMASK_ADDR = 8'hfc;
    localparam logic [7:0] PB_COUNT_ADDR = 8'hfd;

    // Number of buttons that rose this cycle, widened to the COUNT width.
    function automatic logic [7:0] popcount(input logic [NUM_PB-1:0] v);
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < NUM_PB; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pb_event_chan.sv
// One button: edge detect, saturating hold counter, and the sticky PRESS/HOLD flags.
// A flag being set in the same cycle as its W1C clear stays set.
module pb_event_chan
    import pb_pkg::*;
#(
    parameter int                HOLD_W      = 24,
    parameter logic [HOLD_W-1:0] HOLD_CYCLES = 24'd12_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    input  logic press_clr,
    input  logic hold_clr,
    output logic rise,
    output logic press,
    output logic hold
);

    localparam logic [HOLD_W-1:0] HCNT_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_CYCLES - HCNT_ONE;

    logic              prev_r;
    logic [HOLD_W-1:0] hcnt_r;
    logic              press_r;
    logic              hold_r;
    logic              rise_s;
    logic              hold_hit_s;

    assign rise_s     = level & ~prev_r;
    // Fires only on the HOLD_LAST -> HOLD_CYCLES step; saturation blocks re-triggering.
    assign hold_hit_s = level & (hcnt_r == HOLD_LAST);

    // Edge history, hold counter and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r  <= 1'b0;
            hcnt_r  <= {HOLD_W{1'b0}};
            press_r <= 1'b0;
            hold_r  <= 1'b0;
        end else begin
            prev_r <= level;
            if (!level) begin
                hcnt_r <= {HOLD_W{1'b0}};
            end else if (hcnt_r < HOLD_CYCLES) begin
                hcnt_r <= hcnt_r + HCNT_ONE;
            end else begin
                hcnt_r <= hcnt_r;
            end
            press_r <= rise_s | (press_r & ~press_clr);
            hold_r  <= hold_hit_s | (hold_r & ~hold_clr);
        end
    end

    assign rise  = rise_s;
    assign press = press_r;
    assign hold  = hold_r;

endmodule

// File: rtl/pb_event.sv
// Push-button event controller: per-button channels plus masks, press counter,
// interrupt and the CPU read mux at 0xf9-0xfd.
module pb_event
    import pb_pkg::*;
#(
    parameter int                HOLD_W      = 24,
    parameter logic [HOLD_W-1:0] HOLD_CYCLES = 24'd12_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    input  logic [4:0] state,
    output logic [7:0] out,
    output logic       irq
);

    logic [NUM_PB-1:0] rise_s;
    logic [NUM_PB-1:0] press_s;
    logic [NUM_PB-1:0] hold_s;
    logic [NUM_PB-1:0] press_clr_s;
    logic [NUM_PB-1:0] hold_clr_s;
    logic [NUM_PB-1:0] pmask_r;
    logic [NUM_PB-1:0] hmask_r;
    logic [7:0]        count_r;
    logic              irq_r;
    logic [7:0]        out_s;
    logic [7:0]        rise_cnt_s;
    logic              unused_wdata_s;

    assign press_clr_s    = (we && addr == PB_PRESS_ADDR) ? wdata[NUM_PB-1:0] : {NUM_PB{1'b0}};
    assign hold_clr_s     = (we && addr == PB_HOLD_ADDR)  ? wdata[NUM_PB-1:0] : {NUM_PB{1'b0}};
    assign rise_cnt_s     = popcount(rise_s);
    assign unused_wdata_s = &{1'b0, wdata[7:NUM_PB]};

    for (genvar i = 0; i < NUM_PB; i++) begin : g_chan
        pb_event_chan #(
            .HOLD_W      (HOLD_W),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .level     (state[i]),
            .press_clr (press_clr_s[i]),
            .hold_clr  (hold_clr_s[i]),
            .rise      (rise_s[i]),
            .press     (press_s[i]),
            .hold      (hold_s[i])
        );
    end

    // Masks, press counter and registered interrupt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pmask_r <= {NUM_PB{1'b0}};
            hmask_r <= {NUM_PB{1'b0}};
            count_r <= 8'd0;
            irq_r   <= 1'b0;
        end else begin
            if (we && addr == PB_PMASK_ADDR) begin
                pmask_r <= wdata[NUM_PB-1:0];
            end else begin
                pmask_r <= pmask_r;
            end
            if (we && addr == PB_HMASK_ADDR) begin
                hmask_r <= wdata[NUM_PB-1:0];
            end else begin
                hmask_r <= hmask_r;
            end
            // A clearing write still counts rises landing in the same cycle.
            if (we && addr == PB_COUNT_ADDR) begin
                count_r <= rise_cnt_s;
            end else begin
                count_r <= count_r + rise_cnt_s;
            end
            irq_r <= (|(press_s & pmask_r)) | (|(hold_s & hmask_r));
        end
    end

    // Side-effect-free read mux; 0xf8 belongs to the debouncer and reads 0 here.
    always_comb begin
        out_s = 8'd0;
        case (addr)
            PB_PRESS_ADDR: out_s = {3'b000, press_s};
            PB_HOLD_ADDR:  out_s = {3'b000, hold_s};
            PB_PMASK_ADDR: out_s = {3'b000, pmask_r};
            PB_HMASK_ADDR: out_s = {3'b000, hmask_r};
            PB_COUNT_ADDR: out_s = count_r;
            default:       out_s = 8'd0;
        endcase
    end

    assign out = out_s;
    assign irq = irq_r;

endmodule
